mic_clap_detector: RTL and testbench

- Audio-input side of the pet's sound path; consumes ADC samples from the Audio_Controller input FIFO.
- Computes a per-window peak loudness and detects short claps, which the pet FSM uses to wake or attend the pet.
- Sits beside the tone generator at top level and owns the controller's read_audio_in strobe; no other block drives it.

---
 rtl/mic_pkg.sv | 31 +++
 rtl/mic_window_peak.sv | 53 +++++
 rtl/mic_clap_detector.sv | 130 +++++++++++++
 tb/tb_mic_clap_detector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared types and constants for the microphone clap detector.
package mic_pkg;

    // Clap detector FSM states.
    typedef enum logic [1:0] {
        QUIET     = 2'd0,
        LOUD      = 2'd1,
        SUSTAINED = 2'd2,
        COOLDOWN  = 2'd3
    } mic_state_e;

    localparam int MAG_W = 32;

    // Loudness threshold; also the reference for the tone generator amplitudes.
    localparam logic [MAG_W-1:0] DEFAULT_THRESH = 32'd8000000;

    // Stereo mix to mono, then magnitude. Halving each channel first keeps the
    // sum in range; only the most negative mix has no positive twin, so clamp it.
    function automatic logic [MAG_W-1:0] mix_mag(input logic signed [31:0] l,
                                                 input logic signed [31:0] r);
        logic signed [31:0] mix;
        mix = (l >>> 1) + (r >>> 1);
        if (mix == 32'sh8000_0000)
            mix_mag = 32'h7FFF_FFFF;
        else if (mix[31])
            mix_mag = MAG_W'(-mix);
        else
            mix_mag = MAG_W'(mix);
    endfunction

endpackage

// File: rtl/mic_window_peak.sv
// Per-window peak magnitude tracker: mixes L/R, takes |mix|, and reports the
// peak of every 2^WINDOW_LOG2 accepted samples with a one-cycle done pulse.
module mic_window_peak
    import mic_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    accept,
    input  logic                    clear,
    input  logic signed [31:0]      left,
    input  logic signed [31:0]      right,
    output logic [MAG_W-1:0]        win_peak,
    output logic                    win_done
);

    logic [MAG_W-1:0]       mag;
    logic [MAG_W-1:0]       peak;
    logic [MAG_W-1:0]       peak_max;
    logic [WINDOW_LOG2-1:0] cnt;

    assign mag      = mix_mag(left, right);
    assign peak_max = (mag > peak) ? mag : peak;

    // Running peak and sample position; the last sample of a window publishes the peak.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak     <= '0;
            cnt      <= '0;
            win_peak <= '0;
            win_done <= 1'b0;
        end else if (clear) begin
            peak     <= '0;
            cnt      <= '0;
            win_peak <= '0;
            win_done <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (accept) begin
                cnt <= cnt + 1'b1;
                if (cnt == {WINDOW_LOG2{1'b1}}) begin
                    win_peak <= peak_max;
                    peak     <= '0;
                    win_done <= 1'b1;
                end else begin
                    peak <= peak_max;
                end
            end
        end
    end

endmodule

// File: rtl/mic_clap_detector.sv
// Clap detector: drains the audio input FIFO, measures per-window peak
// loudness and emits a one-cycle pulse for short loud bursts.
//
//   state     | meaning
//   QUIET     | idle, waiting for a loud window
//   LOUD      | run of loud windows shorter than MAX_LOUD_WIN
//   SUSTAINED | loud for too long, treated as noise; wait for quiet
//   COOLDOWN  | clap reported, ignore COOLDOWN_WIN windows
module mic_clap_detector
    import mic_pkg::*;
#(
    parameter int               WINDOW_LOG2  = 8,
    parameter logic [MAG_W-1:0] THRESH       = DEFAULT_THRESH,
    parameter int               MAX_LOUD_WIN = 4,
    parameter int               COOLDOWN_WIN = 94
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        read_audio_in,
    input  logic        listenEnable,
    input  logic        toneActive,
    output logic        clapPulse,
    output logic [3:0]  level
);

    localparam int LOUD_W = $clog2(MAX_LOUD_WIN + 1);
    localparam int COOL_W = $clog2(COOLDOWN_WIN + 1);
    localparam logic [LOUD_W-1:0] LOUD_LAST = LOUD_W'(MAX_LOUD_WIN - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_WIN - 1);

    mic_state_e        state, state_next;
    logic [LOUD_W-1:0] loud_cnt, loud_next;
    logic [COOL_W-1:0] cool_cnt, cool_next;
    logic              clap_next;
    logic              accept;
    logic              loud;
    logic [MAG_W-1:0]  win_peak;
    logic              win_done;

    // The FIFO is always drained; samples are only used while listening and silent.
    assign read_audio_in = audio_in_available;
    assign accept        = audio_in_available & listenEnable & ~toneActive;
    assign loud          = win_peak > THRESH;

    mic_window_peak #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_peak (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
        .clear    (~listenEnable),
        .left     (left_channel_audio_in),
        .right    (right_channel_audio_in),
        .win_peak (win_peak),
        .win_done (win_done)
    );

    // Next state and counters; everything advances only when a window completes.
    always_comb begin
        state_next = state;
        loud_next  = loud_cnt;
        cool_next  = cool_cnt;
        clap_next  = 1'b0;
        if (win_done) begin
            case (state)
                QUIET: begin
                    if (loud) begin
                        state_next = LOUD;
                        loud_next  = LOUD_W'(1);
                    end
                end
                LOUD: begin
                    if (loud) begin
                        loud_next = loud_cnt + 1'b1;
                        if (loud_cnt == LOUD_LAST)
                            state_next = SUSTAINED;
                    end else begin
                        clap_next  = 1'b1;
                        state_next = COOLDOWN;
                        loud_next  = '0;
                        cool_next  = '0;
                    end
                end
                SUSTAINED: begin
                    if (!loud) begin
                        state_next = QUIET;
                        loud_next  = '0;
                    end
                end
                COOLDOWN: begin
                    if (cool_cnt == COOL_LAST) begin
                        state_next = QUIET;
                        cool_next  = '0;
                    end else begin
                        cool_next = cool_cnt + 1'b1;
                    end
                end
                default: state_next = QUIET;
            endcase
        end
    end

    // State, counters, pulse and display level; dropping listenEnable clears it all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= QUIET;
            loud_cnt  <= '0;
            cool_cnt  <= '0;
            clapPulse <= 1'b0;
            level     <= '0;
        end else if (!listenEnable) begin
            state     <= QUIET;
            loud_cnt  <= '0;
            cool_cnt  <= '0;
            clapPulse <= 1'b0;
            level     <= '0;
        end else begin
            state     <= state_next;
            loud_cnt  <= loud_next;
            cool_cnt  <= cool_next;
            clapPulse <= clap_next;
            if (win_done)
                level <= win_peak[30:27];
        end
    end

endmodule

// File: tb/tb_mic_clap_detector.sv
// Scoreboard bench for mic_clap_detector: each completed window pushes its
// expected clap/level, popped two cycles after the window's last sample.
module tb_mic_clap_detector;
    import mic_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        avail = 1'b0;
    logic [31:0] lch = '0;
    logic [31:0] rch = '0;
    logic        rd;
    logic        listen = 1'b1;
    logic        tone = 1'b0;
    logic        clap;
    logic [3:0]  level_o;

    mic_clap_detector dut (
        .clk                    (clk),
        .reset                  (reset),
        .audio_in_available     (avail),
        .left_channel_audio_in  (lch),
        .right_channel_audio_in (rch),
        .read_audio_in          (rd),
        .listenEnable           (listen),
        .toneActive             (tone),
        .clapPulse              (clap),
        .level                  (level_o)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       clap;
        logic [3:0] lvl;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pulse = 0;
    int   exp_pulse = 0;

    localparam logic [31:0] LOUD20M = 32'd20000000;
    localparam logic [31:0] MAXPOS  = 32'h7FFF_FFFF;
    localparam logic [31:0] MAXNEG  = 32'h8000_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference level: 64-bit mix so no wrap, then explicit clamp.
    function automatic logic [3:0] lvl_of(input logic [31:0] l, input logic [31:0] r);
        longint lv, rv, m;
        lv = longint'($signed(l));
        rv = longint'($signed(r));
        m  = (lv >>> 1) + (rv >>> 1);
        if (m < 0) m = -m;
        if (m > 64'sh7FFF_FFFF) m = 64'sh7FFF_FFFF;
        return 4'((m >> 27) & 15);
    endfunction

    // Drive n samples, gap idle cycles after each; optionally queue the window result.
    task automatic send(input logic [31:0] l, input logic [31:0] r, input int n, input int gap,
                        input bit push, input logic exp_clap, input logic [3:0] exp_lvl,
                        input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            avail = 1'b1; lch = l; rch = r;
            if (push && i == n - 1) begin
                e.due = cyc + 2; e.clap = exp_clap; e.lvl = exp_lvl; e.tag = tag;
                sb.push_back(e);
                if (exp_clap) exp_pulse++;
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                avail = 1'b0;
            end
        end
        @(posedge clk); #1;
        avail = 1'b0;
    endtask

    task automatic window(input logic [31:0] v, input int gap, input logic exp_clap, input string tag);
        send(v, v, 256, gap, 1'b1, exp_clap, lvl_of(v, v), tag);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b0; avail = 1'b0; listen = 1'b1; tone = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Monitor: pop the scoreboard on the due cycle, flag any unexpected pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (clap) n_pulse++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_clap"}, 32'(clap), 32'(mon_e.clap));
                check({mon_e.tag, "_lvl"}, 32'(level_o), 32'(mon_e.lvl));
            end else if (clap) begin
                check("stray_clap", 32'(clap), 32'd0);
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #25;
        check("rst_clap", 32'(clap), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_state", 32'(dut.state), 32'(QUIET));
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Basic clap, samples every 4th cycle.
        window('0, 3, 1'b0, "a_q0");
        window(LOUD20M, 3, 1'b0, "a_loud");
        window('0, 3, 1'b1, "a_clap");

        // Cooldown: windows 1..93 ignored, 94th loud is ignored too.
        window(LOUD20M, 0, 1'b0, "b_cd_loud");
        window('0, 0, 1'b0, "b_cd_quiet");
        for (int w = 3; w <= 93; w++) window('0, 0, 1'b0, "b_cd");
        check("b_state93", 32'(dut.state), 32'(COOLDOWN));
        window(LOUD20M, 0, 1'b0, "b_cd94");
        check("b_state94", 32'(dut.state), 32'(QUIET));
        window(LOUD20M, 0, 1'b0, "b_loud");
        check("b_state95", 32'(dut.state), 32'(LOUD));
        window('0, 0, 1'b1, "b_clap");

        // Sustained noise: four loud windows, then quiet, no pulse.
        do_reset();
        for (int w = 0; w < 3; w++) window(LOUD20M, 0, 1'b0, "s_loud");
        check("s_state3", 32'(dut.state), 32'(LOUD));
        window(LOUD20M, 0, 1'b0, "s_loud4");
        check("s_state4", 32'(dut.state), 32'(SUSTAINED));
        window('0, 0, 1'b0, "s_quiet");
        check("s_state_q", 32'(dut.state), 32'(QUIET));

        // Saturation, then listenEnable drop while LOUD.
        window(MAXNEG, 0, 1'b0, "m_neg");
        check("m_winpeak", dut.u_peak.win_peak, 32'h7FFF_FFFF);
        check("m_state", 32'(dut.state), 32'(LOUD));
        window(MAXPOS, 0, 1'b0, "m_pos");
        @(posedge clk); #1;
        listen = 1'b0; avail = 1'b1; lch = MAXPOS; rch = MAXPOS;
        check("l_rd_hi", 32'(rd), 32'd1);
        @(posedge clk); #1;
        check("l_level", 32'(level_o), 32'd0);
        check("l_state", 32'(dut.state), 32'(QUIET));
        avail = 1'b0;
        check("l_rd_lo", 32'(rd), 32'd0);
        send(MAXPOS, MAXPOS, 256, 0, 1'b0, 1'b0, 4'h0, "");
        listen = 1'b1;
        window('0, 0, 1'b0, "l_quiet");

        // toneActive drops samples but keeps window position.
        tone = 1'b1;
        @(posedge clk); #1;
        avail = 1'b1;
        check("t_rd", 32'(rd), 32'd1);
        @(posedge clk); #1;
        avail = 1'b0;
        tone = 1'b0;
        send('0, '0, 100, 0, 1'b0, 1'b0, 4'h0, "");
        tone = 1'b1;
        send(MAXPOS, MAXPOS, 50, 0, 1'b0, 1'b0, 4'h0, "");
        tone = 1'b0;
        send('0, '0, 156, 0, 1'b1, 1'b0, 4'h0, "t_win");
        repeat (3) @(posedge clk);
        #1;
        check("t_cnt", 32'(dut.u_peak.cnt), 32'd0);
        check("t_state", 32'(dut.state), 32'(QUIET));

        // Asynchronous reset mid-window while LOUD.
        window(MAXPOS, 0, 1'b0, "r_loud");
        check("r_level_pre", 32'(level_o), 32'hF);
        send('0, '0, 100, 0, 1'b0, 1'b0, 4'h0, "");
        @(posedge clk); #5;
        reset = 1'b0;
        #1;
        check("r_level", 32'(level_o), 32'd0);
        check("r_clap", 32'(clap), 32'd0);
        check("r_state", 32'(dut.state), 32'(QUIET));
        check("r_cnt", 32'(dut.u_peak.cnt), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        window(LOUD20M, 3, 1'b0, "r2_loud");
        window('0, 3, 1'b1, "r2_clap");

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("pulse_count", 32'(n_pulse), 32'(exp_pulse));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
